// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } arb_state_t;

  localparam int TMO_W = 16;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin find-first: returns the first set request at or
// after ptr, wrapping past NUM_REQ-1 back to 0.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               valid,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_REQ-1:0] doubled;
  logic [NUM_REQ-1:0]   rotated;
  logic [ID_W:0]        sum;

  // Rotate so that bit 0 is the pointer position; scanning downward lets the
  // lowest rotated offset win without needing a break.
  always_comb begin
    doubled = {req, req} >> ptr;
    rotated = doubled[NUM_REQ-1:0];
    valid   = 1'b0;
    sum     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rotated[k]) begin
        valid = 1'b1;
        sum   = {1'b0, ptr} + (ID_W + 1)'(k);
      end
    end
    if (sum >= (ID_W + 1)'(NUM_REQ)) begin
      sum = sum - (ID_W + 1)'(NUM_REQ);
    end
    idx = sum[ID_W-1:0];
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_transmitter among NUM_REQ byte clients.
// Define UART_ARB_PRIORITY_EN to make requester 0 a strict high-priority client.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 arb_enable,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           Tx_DATA,
  output logic                 Tx_WR,
  output logic                 Tx_EN,
  input  logic                 Tx_BUSY,
  output logic [ID_W-1:0]      owner,
  output logic                 busy,
  output logic                 arb_error
);

  arb_state_t         state;
  logic [ID_W-1:0]    rr_ptr;
  logic [TMO_W-1:0]   tmo_cnt;
  logic [NUM_REQ-1:0] pick_req;
  logic               rr_valid;
  logic [ID_W-1:0]    rr_idx;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_idx;
  logic [ID_W-1:0]    ptr_after_owner;

`ifdef UART_ARB_PRIORITY_EN
  assign pick_req = {req[NUM_REQ-1:1], 1'b0};
`else
  assign pick_req = req;
`endif

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (pick_req),
    .ptr   (rr_ptr),
    .valid (rr_valid),
    .idx   (rr_idx)
  );

  // Requester 0 pre-empts the rotation when priority mode is built in, and
  // then leaves the pointer untouched so the others keep their turn order.
  always_comb begin
    grant_valid     = rr_valid;
    grant_idx       = rr_idx;
    ptr_after_owner = (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
`ifdef UART_ARB_PRIORITY_EN
    if (req[0]) begin
      grant_valid = 1'b1;
      grant_idx   = '0;
    end
    if (owner == '0) begin
      ptr_after_owner = rr_ptr;
    end
`endif
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      tmo_cnt   <= '0;
      Tx_DATA   <= '0;
      Tx_WR     <= 1'b0;
      Tx_EN     <= 1'b0;
      owner     <= '0;
      req_ack   <= '0;
      req_done  <= '0;
      arb_error <= 1'b0;
    end else begin
      req_ack   <= '0;
      req_done  <= '0;
      arb_error <= 1'b0;
      Tx_EN     <= arb_enable | (state != IDLE);
      case (state)
        IDLE: begin
          if (arb_enable && (|req)) begin
            state <= GRANT;
          end
        end
        GRANT: begin
          if (grant_valid) begin
            Tx_DATA <= req_data[{grant_idx, 3'b000} +: 8];
            owner   <= grant_idx;
            req_ack <= NUM_REQ'(1) << grant_idx;
            Tx_WR   <= 1'b1;
            tmo_cnt <= '0;
            state   <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        // Counting from zero keeps Tx_WR high for exactly BUSY_TIMEOUT cycles.
        LOAD: begin
          if (Tx_BUSY) begin
            Tx_WR <= 1'b0;
            state <= SEND;
          end else if (tmo_cnt == TMO_W'(BUSY_TIMEOUT - 1)) begin
            Tx_WR     <= 1'b0;
            arb_error <= 1'b1;
            rr_ptr    <= ptr_after_owner;
            state     <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        SEND: begin
          if (!Tx_BUSY) begin
            req_done <= NUM_REQ'(1) << owner;
            state    <= DONE;
          end
        end
        DONE: begin
          rr_ptr <= ptr_after_owner;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural transmitter and
// a turn-order reference model.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int TMO     = 16;

  logic                 clk;
  logic                 reset;
  logic                 arb_enable;
  logic [NUM_REQ-1:0]   req;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   req_done;
  logic [7:0]           Tx_DATA;
  logic                 Tx_WR;
  logic                 Tx_EN;
  logic                 Tx_BUSY;
  logic [ID_W-1:0]      owner;
  logic                 busy;
  logic                 arb_error;

  int         total;
  int         bad;
  int         ack_q[$];
  int         done_q[$];
  logic [7:0] sent_q[$];
  int         err_cnt;
  bit         tx_model_on;
  bit         auto_clear;
  int         model_ptr;

  uart_tx_arbiter #(
    .NUM_REQ      (NUM_REQ),
    .ID_W         (ID_W),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arb_enable (arb_enable),
    .req        (req),
    .req_data   (req_data),
    .req_ack    (req_ack),
    .req_done   (req_done),
    .Tx_DATA    (Tx_DATA),
    .Tx_WR      (Tx_WR),
    .Tx_EN      (Tx_EN),
    .Tx_BUSY    (Tx_BUSY),
    .owner      (owner),
    .busy       (busy),
    .arb_error  (arb_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Transmitter stand-in: answers a write strobe after a short random delay,
  // stays busy for a random frame length and records the byte it took.
  initial begin : tx_model
    Tx_BUSY = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_model_on && reset && Tx_WR && !Tx_BUSY) begin
        int d;
        int len;
        d   = $urandom_range(0, 2);
        len = $urandom_range(3, 8);
        for (int k = 0; k < d && reset; k++) @(negedge clk);
        if (reset) begin
          Tx_BUSY = 1'b1;
          sent_q.push_back(Tx_DATA);
          for (int k = 0; k < len && reset; k++) @(negedge clk);
          Tx_BUSY = 1'b0;
        end
      end
    end
  end

  // Reference turn order: first pending requester at or after the pointer.
  function automatic int model_pick(input logic [NUM_REQ-1:0] mask, input int ptr);
`ifdef UART_ARB_PRIORITY_EN
    if (mask[0]) return 0;
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    end
    return -1;
  endfunction

  function automatic int model_next(input int w, input int ptr);
`ifdef UART_ARB_PRIORITY_EN
    if (w == 0) return ptr;
`endif
    return (w + 1) % NUM_REQ;
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ack[i] === 1'b1) begin
        ack_q.push_back(i);
        if (auto_clear) req[i] = 1'b0;
      end
      if (req_done[i] === 1'b1) done_q.push_back(i);
    end
    if (arb_error === 1'b1) err_cnt++;
  endtask

  task automatic wait_acks(input int n, output bit ok);
    int budget = 2000;
    while (ack_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    ok = (ack_q.size() >= n);
  endtask

  task automatic wait_dones(input int n, output bit ok);
    int budget = 2000;
    while (done_q.size() < n && budget > 0) begin
      step();
      budget--;
    end
    ok = (done_q.size() >= n);
  endtask

  task automatic wait_idle(output bit ok);
    int budget = 200;
    step();
    while ((busy !== 1'b0 || Tx_BUSY !== 1'b0) && budget > 0) begin
      step();
      budget--;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    reset      = 1'b0;
    arb_enable = 1'b1;
    req        = 4'b1111;
    req_data   = 32'h44332211;
    repeat (3) step();
    total++;
    if ({Tx_DATA, Tx_WR, Tx_EN, owner, req_ack, req_done, busy, arb_error} !== 22'd0)
      begin bad++; $display("[TB] FAIL reset_outputs: got %h expected 0",
        {Tx_DATA, Tx_WR, Tx_EN, owner, req_ack, req_done, busy, arb_error}); end
    req = '0;
    step();
    reset = 1'b1;
    repeat (2) step();
    total++;
    if ({Tx_EN, busy} !== 2'b10) begin
      bad++; $display("[TB] FAIL idle_enable: got %b expected 10", {Tx_EN, busy});
    end
    model_ptr = 0;
  endtask

  task automatic test_single();
    bit ok;
    int db = done_q.size();
    int sb = sent_q.size();
    req_data = 32'h000000EB;
    req      = 4'b0001;
    step();
    total++;
    if ({busy, req_ack} !== 5'b10000) begin
      bad++; $display("[TB] FAIL single_grant: got %b expected 10000", {busy, req_ack});
    end
    step();
    total++;
    if ({req_ack, Tx_WR, Tx_DATA, owner} !== {4'b0001, 1'b1, 8'hEB, 2'd0}) begin
      bad++; $display("[TB] FAIL single_load: got %h expected %h",
        {req_ack, Tx_WR, Tx_DATA, owner}, {4'b0001, 1'b1, 8'hEB, 2'd0});
    end
    wait_dones(db + 1, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL single_done_wait: got none expected 1 done"); end
    total++;
    if (done_q[db] !== 0 || sent_q[sb] !== 8'hEB) begin
      bad++; $display("[TB] FAIL single_frame: got done=%0d byte=%h expected done=0 byte=eb",
        done_q[db], sent_q[sb]);
    end
    wait_idle(ok);
    model_ptr = model_next(0, model_ptr);
  endtask

  task automatic test_enable();
    bit ok;
    int ab = ack_q.size();
    int w;
    arb_enable = 1'b0;
    req_data   = 32'h5A000000;
    req        = 4'b1000;
    repeat (10) step();
    total++;
    if ({Tx_EN, busy, 32'(ack_q.size())} !== {2'b00, 32'(ab)}) begin
      bad++; $display("[TB] FAIL enable_off: got en=%b busy=%b acks=%0d expected 0 0 %0d",
        Tx_EN, busy, ack_q.size(), ab);
    end
    w = model_pick(4'b1000, model_ptr);
    arb_enable = 1'b1;
    wait_acks(ab + 1, ok);
    total++;
    if (!ok || ack_q[ab] !== w) begin
      bad++; $display("[TB] FAIL enable_on: got %0d expected %0d", ack_q[ab], w);
    end
    model_ptr = model_next(w, model_ptr);
    wait_idle(ok);
  endtask

  task automatic test_fairness();
    bit ok;
    int ab = ack_q.size();
    int sb = sent_q.size();
    int db = done_q.size();
    int exp_w[5];
    for (int i = 0; i < 5; i++) begin
      exp_w[i]  = model_pick(4'b1111, model_ptr);
      model_ptr = model_next(exp_w[i], model_ptr);
    end
    auto_clear = 1'b0;
    req_data   = 32'h44332211;
    req        = 4'b1111;
    wait_acks(ab + 5, ok);
    req        = '0;
    auto_clear = 1'b1;
    wait_dones(db + 5, ok);
    total++;
    if (!ok) begin bad++; $display("[TB] FAIL fair_wait: got %0d dones expected 5", done_q.size() - db); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (ack_q[ab + i] !== exp_w[i] || sent_q[sb + i] !== 8'(exp_w[i] * 17 + 17)) begin
        bad++; $display("[TB] FAIL fair_order[%0d]: got req=%0d byte=%h expected req=%0d byte=%h",
          i, ack_q[ab + i], sent_q[sb + i], exp_w[i], 8'(exp_w[i] * 17 + 17));
      end
    end
    wait_idle(ok);
  endtask

  task automatic test_wrap();
    bit ok;
    logic [NUM_REQ-1:0] masks[2];
    masks[0] = 4'b0100;
    masks[1] = 4'b1001;
    req_data = 32'hD4C3B2A1;
    for (int m = 0; m < 2; m++) begin
      int ab = ack_q.size();
      int sb = sent_q.size();
      int db = done_q.size();
      int n = $countones(masks[m]);
      int exp_w[$];
      logic [NUM_REQ-1:0] pend = masks[m];
      while (pend != '0) begin
        int w = model_pick(pend, model_ptr);
        exp_w.push_back(w);
        model_ptr = model_next(w, model_ptr);
        pend[w] = 1'b0;
      end
      req = masks[m];
      wait_dones(db + n, ok);
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL wrap_wait: got %0d dones expected %0d", done_q.size() - db, n); end
      for (int i = 0; i < n; i++) begin
        total++;
        if (ack_q[ab + i] !== exp_w[i] || sent_q[sb + i] !== req_data[8*exp_w[i] +: 8]) begin
          bad++; $display("[TB] FAIL wrap_order[%0d]: got req=%0d byte=%h expected req=%0d byte=%h",
            i, ack_q[ab + i], sent_q[sb + i], exp_w[i], req_data[8*exp_w[i] +: 8]);
        end
      end
      wait_idle(ok);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    int ab = ack_q.size();
    int db = done_q.size();
    int eb = err_cnt;
    int wr_cycles = 0;
    int w;
    tx_model_on = 1'b0;
    req_data    = 32'h00770000;
    req         = 4'b0100;
    w           = model_pick(4'b0100, model_ptr);
    wait_acks(ab + 1, ok);
    while (Tx_WR === 1'b1 && wr_cycles < 100) begin
      wr_cycles++;
      step();
    end
    total++;
    if (wr_cycles !== TMO) begin
      bad++; $display("[TB] FAIL timeout_wr_len: got %0d expected %0d", wr_cycles, TMO);
    end
    repeat (3) step();
    total++;
    if (err_cnt - eb !== 1 || done_q.size() !== db || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL timeout_result: got err=%0d dones=%0d busy=%b expected 1 0 0",
        err_cnt - eb, done_q.size() - db, busy);
    end
    model_ptr   = model_next(w, model_ptr);
    tx_model_on = 1'b1;
  endtask

  task automatic test_random();
    bit ok;
    for (int r = 0; r < 6; r++) begin
      int ab = ack_q.size();
      int sb = sent_q.size();
      int db = done_q.size();
      logic [NUM_REQ-1:0] mask = NUM_REQ'($urandom_range(1, 15));
      logic [NUM_REQ-1:0] pend = mask;
      int n = $countones(mask);
      int exp_w[$];
      req_data = $urandom();
      while (pend != '0) begin
        int w = model_pick(pend, model_ptr);
        exp_w.push_back(w);
        model_ptr = model_next(w, model_ptr);
        pend[w] = 1'b0;
      end
      req = mask;
      wait_dones(db + n, ok);
      total++;
      if (!ok) begin bad++; $display("[TB] FAIL rand_wait[%0d]: got %0d dones expected %0d", r, done_q.size() - db, n); end
      for (int i = 0; i < n; i++) begin
        total++;
        if (ack_q[ab + i] !== exp_w[i] || done_q[db + i] !== exp_w[i] ||
            sent_q[sb + i] !== req_data[8*exp_w[i] +: 8]) begin
          bad++; $display("[TB] FAIL rand_order[%0d.%0d]: got ack=%0d done=%0d byte=%h expected %0d byte=%h",
            r, i, ack_q[ab + i], done_q[db + i], sent_q[sb + i], exp_w[i], req_data[8*exp_w[i] +: 8]);
        end
      end
      wait_idle(ok);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int budget = 200;
    int db = done_q.size();
    int sb;
    req_data = 32'h5A000000;
    req      = 4'b1000;
    while (Tx_BUSY !== 1'b1 && budget > 0) begin step(); budget--; end
    step();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({Tx_DATA, Tx_WR, Tx_EN, owner, req_ack, req_done, busy, arb_error} !== 22'd0) begin
      bad++; $display("[TB] FAIL reset_mid_async: got %h expected 0",
        {Tx_DATA, Tx_WR, Tx_EN, owner, req_ack, req_done, busy, arb_error});
    end
    req = '0;
    repeat (3) step();
    reset     = 1'b1;
    model_ptr = 0;
    repeat (10) step();
    total++;
    if (done_q.size() !== db) begin
      bad++; $display("[TB] FAIL reset_mid_no_done: got %0d expected 0", done_q.size() - db);
    end
    sb       = sent_q.size();
    req_data = 32'h0000AB00;
    req      = 4'b0010;
    wait_dones(db + 1, ok);
    total++;
    if (!ok || done_q[db] !== 1 || sent_q[sb] !== 8'hAB) begin
      bad++; $display("[TB] FAIL reset_mid_resume: got done=%0d byte=%h expected done=1 byte=ab",
        done_q[db], sent_q[sb]);
    end
    model_ptr = model_next(1, model_ptr);
    wait_idle(ok);
  endtask

`ifdef UART_ARB_PRIORITY_EN
  task automatic test_priority();
    bit ok;
    int ab = ack_q.size();
    int db = done_q.size();
    int exp_w[3];
    logic [NUM_REQ-1:0] pend = 4'b0110;
    exp_w[0]  = model_pick(pend, model_ptr);
    model_ptr = model_next(exp_w[0], model_ptr);
    pend[exp_w[0]] = 1'b0;
    pend[0]   = 1'b1;
    for (int i = 1; i < 3; i++) begin
      exp_w[i]  = model_pick(pend, model_ptr);
      model_ptr = model_next(exp_w[i], model_ptr);
      pend[exp_w[i]] = 1'b0;
    end
    req_data = 32'h00C3B2A1;
    req      = 4'b0110;
    wait_acks(ab + 1, ok);
    req[0]   = 1'b1;
    wait_dones(db + 3, ok);
    for (int i = 0; i < 3; i++) begin
      total++;
      if (ack_q[ab + i] !== exp_w[i]) begin
        bad++; $display("[TB] FAIL prio_order[%0d]: got %0d expected %0d", i, ack_q[ab + i], exp_w[i]);
      end
    end
    wait_idle(ok);
  endtask
`endif

  initial begin
    total       = 0;
    bad         = 0;
    err_cnt     = 0;
    tx_model_on = 1'b1;
    auto_clear  = 1'b1;
    model_ptr   = 0;
    reset       = 1'b0;
    arb_enable  = 1'b0;
    req         = '0;
    req_data    = '0;
    test_reset();
    test_single();
    test_enable();
    test_fairness();
    test_wrap();
    test_timeout();
    test_random();
    test_reset_mid();
`ifdef UART_ARB_PRIORITY_EN
    test_priority();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
